mod_sub_one_2c: RTL
===================

MOD_SUB_ONE_2C -- requirements
Module: mod_sub_one_2c

Interface
REQ-001 Parameter DATA_WIDTH, default 18, SHALL set the width of the residue digit.
REQ-002 Parameter MODULUS, default 177147, SHALL set the digit modulus M; legal inputs are 0..M-1 and M SHALL be at most 2^DATA_WIDTH.
REQ-003 Port clk, input, 1 bit, SHALL be the single rising-edge clock.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL mark A/bin as valid.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate the block accepts an input this cycle.
REQ-007 Port A, input, DATA_WIDTH bits, SHALL carry the residue digit to decrement.
REQ-008 Port bin, input, 1 bit, SHALL carry the borrow-in (decrement amount, 0 or 1).
REQ-009 Port out_valid, output, 1 bit, SHALL mark result/bout/range_err as valid.
REQ-010 Port out_ready, input, 1 bit, SHALL indicate the sink accepts the output this cycle.
REQ-011 Port result, output, DATA_WIDTH bits: (A - bin) mod M.
REQ-012 Port bout, output, 1 bit, SHALL be set when the decrement wrapped below zero.
REQ-013 Port range_err, output, 1 bit, SHALL flag an input with A >= M.
REQ-014 Port err_sticky, output, 1 bit, SHALL hold 1 once any accepted input had range_err, until reset or err_clr.
REQ-015 Port err_clr, input, 1 bit, SHALL clear err_sticky.

Function
REQ-016 The block SHALL be a two-stage registered pipeline (S1, S2), each stage holding a valid bit and a data payload.
REQ-017 Pipeline enable SHALL be en = out_ready OR NOT out_valid; in_ready SHALL equal en combinationally.
REQ-018 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-019 When en=1, S1 SHALL load {in_valid AND in_ready, A, bin}, and S2 SHALL load S1's valid bit and its stage-2 computation; when en=0, both stages SHALL hold unchanged.
REQ-020 S1 SHALL compute diff = A - bin in DATA_WIDTH+1 bits (sign in MSB) and rerr = (A >= M).
REQ-021 S2 SHALL produce: if rerr, then result=0, bout=0, range_err=1; else if diff is negative, then result=M-1, bout=1; else result=diff[DATA_WIDTH-1:0], bout=0.
REQ-022 Latency SHALL be exactly 2 clock edges from input transfer to out_valid with out_ready held at 1; throughput SHALL be one result per cycle.
REQ-023 Bubbles SHALL NOT be collapsed; an empty S1 advances as an invalid entry into S2.
REQ-024 Output ports SHALL be driven directly from S2 registers with no combinational path from A/bin.
REQ-025 Results SHALL emerge in acceptance order, with none dropped or duplicated under any out_ready pattern.
REQ-026 Boundary A=0, bin=1: result=M-1, bout=1.
REQ-027 Boundary A=M-1, bin=0: result=M-1, bout=0.
REQ-028 Boundary A=0, bin=0: result=0, bout=0.
REQ-029 err_sticky SHALL set on the edge where S2 loads a valid entry with rerr=1.
REQ-030 If err_clr is asserted on the same edge as a set, the set SHALL win.
REQ-031 While out_ready=0 and out_valid=1, result, bout and range_err SHALL remain stable.

Reset
REQ-032 While reset=1 at a rising edge, both stage valid bits, err_sticky, result, bout and range_err SHALL go to 0.
REQ-033 During and after reset, out_valid SHALL be 0 and in_ready SHALL be 1 on the first cycle after reset is released.
REQ-034 Reset mid-operation SHALL discard all in-flight entries, with no output transfer for them after reset.
REQ-035 Reset SHALL take priority over en, in_valid and err_clr.

Verification
REQ-036 Reset, then A=5, bin=1, out_ready=1 -> two edges later out_valid=1, result=4, bout=0.
REQ-037 Send A=0, bin=1, then A=177146, bin=0 back to back -> results 177146/bout=1, then 177146/bout=0 on consecutive cycles.
REQ-038 Send A=177147, bin=0 -> result=0, range_err=1, err_sticky=1 from the next edge; pulse err_clr -> err_sticky=0.
REQ-039 Stream values 10,9,8 with out_ready low for 3 cycles after the first out_valid -> in_ready=0 during the stall, output holds 9 (bin=1), and sequence 9,8,7 is delivered in order with no loss.
REQ-040 Assert reset with two entries in flight -> out_valid=0 the next cycle and no stale result afterward.
REQ-041 Random A in 0..M-1 with random bin, in_valid and out_ready for 10k cycles -> a scoreboard matches (A-bin) mod M and bout exactly.

Source files
------------

// File: rtl/mod_sub_one_2c.sv
// Modular decrement of one residue digit: result = (A - bin) mod MODULUS.
// Two-stage valid/ready pipeline; an out-of-range digit flags range_err and sets err_sticky.
module mod_sub_one_2c #(
    parameter int DATA_WIDTH = 18,
    parameter int MODULUS    = 177147
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  bout,
    output logic                  range_err,
    output logic                  err_sticky,
    input  logic                  err_clr
);

    // MODULUS may equal 2^DATA_WIDTH, so range compare needs one extra bit
    localparam logic [DATA_WIDTH:0]   MOD_EXT   = (DATA_WIDTH+1)'(MODULUS);
    localparam logic [DATA_WIDTH-1:0] M_MINUS_1 = DATA_WIDTH'(MODULUS - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  bout;
        logic                  range_err;
    } s2_t;

    function automatic s2_t wrap_digit(input logic rerr, input logic signed [DATA_WIDTH:0] diff);
        s2_t o;
        o.result    = '0;
        o.bout      = 1'b0;
        o.range_err = 1'b0;
        if (rerr) begin
            o.range_err = 1'b1;
        end else if (diff[DATA_WIDTH]) begin
            o.result = M_MINUS_1;
            o.bout   = 1'b1;
        end else begin
            o.result = diff[DATA_WIDTH-1:0];
        end
        return o;
    endfunction

    logic                         en;
    logic                         vld_p1;
    logic signed [DATA_WIDTH:0]   diff_p1;
    logic                         rerr_p1;
    logic                         vld_p2;
    s2_t                          s2_next;
    s2_t                          s2_p2;
    logic signed [DATA_WIDTH:0]   diff_in;
    logic                         rerr_in;

    assign en       = out_ready | ~vld_p2;
    assign in_ready = en;

    assign diff_in = $signed({1'b0, A}) - $signed({{DATA_WIDTH{1'b0}}, bin});
    assign rerr_in = ({1'b0, A} >= MOD_EXT);
    assign s2_next = wrap_digit(rerr_p1, diff_p1);

    // ---- stage 1: subtract and range test ----
    always_ff @(posedge clk) begin
        if (en) begin
            diff_p1 <= diff_in;
            rerr_p1 <= rerr_in;
        end
    end

    // ---- stage 2: modular wrap, output registers, sticky error ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            s2_p2      <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (en) begin
                vld_p1 <= in_valid & in_ready;
                vld_p2 <= vld_p1;
                s2_p2  <= s2_next;
            end
            // a set on the same edge as err_clr wins
            if (en && vld_p1 && rerr_p1) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;
    assign result    = s2_p2.result;
    assign bout      = s2_p2.bout;
    assign range_err = s2_p2.range_err;

endmodule
